// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is split into STAGES
// segments, one per pipeline stage. All stages stall together under output backpressure.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4    // WIDTH must be a multiple of STAGES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             subtract,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int SEG = WIDTH / STAGES;

   logic [STAGES-1:0]            valid_reg;
   logic [STAGES-1:0]            carry_reg;
   logic [STAGES-1:0][WIDTH-1:0] a_reg;
   logic [STAGES-1:0][WIDTH-1:0] b_reg;
   logic [STAGES-1:0][WIDTH-1:0] res_reg;
   logic                         overflow_reg;
   logic                         zero_reg;
   logic                         stall;

   assign stall    = valid_reg[STAGES-1] && !out_ready;
   assign in_ready = !stall;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : gen_stage
         localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (gi * SEG);

         logic             valid_in;
         logic             cin;
         logic [WIDTH-1:0] a_in;
         logic [WIDTH-1:0] b_in;
         logic [WIDTH-1:0] res_in;
         logic [SEG:0]     seg_sum;
         logic [WIDTH-1:0] res_next;

         if (gi == 0) begin : gen_first
            // b is inverted and the carry-in set here, so subtract becomes a + ~b + 1
            assign valid_in = in_valid && !stall;
            assign a_in     = operand_a;
            assign b_in     = subtract ? ~operand_b : operand_b;
            assign res_in   = '0;
            assign cin      = subtract;
         end else begin : gen_next
            assign valid_in = valid_reg[gi-1];
            assign a_in     = a_reg[gi-1];
            assign b_in     = b_reg[gi-1];
            assign res_in   = res_reg[gi-1];
            assign cin      = carry_reg[gi-1];
         end

         assign seg_sum  = {1'b0, a_in[gi*SEG +: SEG]} + {1'b0, b_in[gi*SEG +: SEG]}
                         + {{SEG{1'b0}}, cin};
         assign res_next = (res_in & ~SEG_MASK) | (WIDTH'(seg_sum[SEG-1:0]) << (gi * SEG));

         always_ff @(posedge clock) begin
            if (reset) begin
               valid_reg[gi] <= 1'b0;
               carry_reg[gi] <= 1'b0;
               a_reg[gi]     <= '0;
               b_reg[gi]     <= '0;
               res_reg[gi]   <= '0;
            end else if (!stall) begin
               valid_reg[gi] <= valid_in;
               carry_reg[gi] <= seg_sum[SEG];
               a_reg[gi]     <= a_in;
               b_reg[gi]     <= b_in;
               res_reg[gi]   <= res_next;
            end
         end

         if (gi == STAGES - 1) begin : gen_flags
            always_ff @(posedge clock) begin
               if (reset) begin
                  overflow_reg <= 1'b0;
                  zero_reg     <= 1'b0;
               end else if (!stall) begin
                  overflow_reg <= (a_in[WIDTH-1] == b_in[WIDTH-1])
                                  && (res_next[WIDTH-1] != a_in[WIDTH-1]);
                  zero_reg     <= ~|res_next;
               end
            end
         end
      end
   endgenerate

   // Operand bits below the active segment are carried along but never read downstream
   logic pipe_unused;
   assign pipe_unused = ^{a_reg, b_reg};

   assign out_valid = valid_reg[STAGES-1];
   assign result    = res_reg[STAGES-1];
   assign carry_out = carry_reg[STAGES-1];
   assign overflow  = overflow_reg;
   assign zero      = zero_reg;

endmodule
